data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/load_align.sv | 26 ++
 rtl/data_mem_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    localparam logic [7:0] LANE_MASK_B = 8'h01;
    localparam logic [7:0] LANE_MASK_H = 8'h03;
    localparam logic [7:0] LANE_MASK_W = 8'h0F;
    localparam logic [7:0] LANE_MASK_D = 8'hFF;

    // Byte-enable pattern for an access of the given size starting at lane 0.
    function automatic logic [7:0] size_mask(input size_e size);
        case (size)
            SZ_BYTE: size_mask = LANE_MASK_B;
            SZ_HALF: size_mask = LANE_MASK_H;
            SZ_WORD: size_mask = LANE_MASK_W;
            default: size_mask = LANE_MASK_D;
        endcase
    endfunction

    // True when the low address bits break natural alignment for the size.
    function automatic logic misaligned(input size_e size, input logic [2:0] lane);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = |lane[1:0];
            default: misaligned = |lane;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Moves the addressed bytes of a doubleword down to bit 0 and extends them.
module load_align
    import mem_pkg::*;
(
    input  logic [63:0] dword,
    input  logic [2:0]  lane,
    input  size_e       size,
    input  logic        uns,
    output logic [63:0] data
);

    logic [63:0] shifted;

    // Lane shift followed by sign or zero extension.
    always_comb begin
        shifted = dword >> {lane, 3'b000};
        data    = shifted;
        case (size)
            SZ_BYTE: data = {{56{~uns & shifted[7]}},  shifted[7:0]};
            SZ_HALF: data = {{48{~uns & shifted[15]}}, shifted[15:0]};
            SZ_WORD: data = {{32{~uns & shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder over a doubleword register array.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [1:0]  SIZE,
    input  logic        UNS,
    input  logic [31:0] ADDR,
    input  logic [63:0] WDATA,
    output logic        READY,
    output logic        ACK,
    output logic [63:0] RDATA,
    output logic        ERR
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  LAT_INIT = 4'((LATENCY == 0) ? 32'd0 : LATENCY - 1);

    state_e      state;
    logic [3:0]  cnt;
    logic        we_q;
    size_e       size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] mem [DEPTH];

    logic             accept;
    logic             to_resp;
    logic             sel_we;
    size_e            sel_size;
    logic             sel_uns;
    logic [31:0]      sel_addr;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_fault;
    logic [63:0]      load_data;
    logic             commit;
    logic [7:0]       wr_mask;
    logic [63:0]      wr_data;

    assign accept = REQ && READY && (state == IDLE);

    // With zero latency the response is formed from the live request, otherwise from the captured one.
    always_comb begin
        sel_we   = we_q;
        sel_size = size_q;
        sel_uns  = uns_q;
        sel_addr = addr_q;
        if (state == IDLE) begin
            sel_we   = WE;
            sel_size = size_e'(SIZE);
            sel_uns  = UNS;
            sel_addr = ADDR;
        end
        sel_idx   = sel_addr[3 +: IDX_W];
        sel_fault = misaligned(sel_size, sel_addr[2:0]) || (32'(sel_addr[31:3]) >= DEPTH);
        to_resp   = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd0));
    end

    load_align u_load_align (
        .dword (mem[sel_idx]),
        .lane  (sel_addr[2:0]),
        .size  (sel_size),
        .uns   (sel_uns),
        .data  (load_data)
    );

    // Request capture on accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= WE;
            size_q  <= size_e'(SIZE);
            uns_q   <= UNS;
            addr_q  <= ADDR;
            wdata_q <= WDATA;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 4'd0;
            READY <= 1'b0;
            ACK   <= 1'b0;
            RDATA <= '0;
            ERR   <= 1'b0;
        end else begin
            ACK   <= 1'b0;
            RDATA <= '0;
            ERR   <= 1'b0;
            if (to_resp) begin
                ACK   <= 1'b1;
                ERR   <= sel_fault;
                RDATA <= (sel_fault || sel_we) ? 64'd0 : load_data;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        READY <= 1'b0;
                        cnt   <= LAT_INIT;
                        state <= (LATENCY == 0) ? RESP : WAIT;
                    end else begin
                        READY <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    READY <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    READY <= 1'b0;
                end
            endcase
        end
    end

    // A store lands on the edge that closes RESP, so a reset during RESP drops it.
    assign commit  = (state == RESP) && we_q && !ERR && !RST;
    assign wr_mask = size_mask(size_q) << addr_q[2:0];
    assign wr_data = wdata_q << {addr_q[2:0], 3'b000};

    // Byte-merged write into the addressed doubleword; contents survive reset.
    always_ff @(posedge CLK) begin
        if (commit) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_mask[b]) begin
                    mem[addr_q[3 +: IDX_W]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule
